// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : rst_seq
//  Purpose  : Staged reset sequencer. Releases NUM_STAGES active-low subsystem
//             resets strictly in index order. Each stage waits a settle delay,
//             is released, and must then acknowledge on ready_i before the
//             next stage starts its delay. A ready timeout, or a ready loss
//             after everything is up, latches a fault and pulls every stage
//             back into reset until rst or soft_rst_i.
//  Ports    : clkin          system clock
//             rst            synchronous active-high reset
//             soft_rst_i     synchronous pulse, restarts the sequence
//             ready_i        per-stage ready (asynchronous, synchronised here)
//             rst_n_stage_o  per-stage reset, active low, registered
//             all_ready_o    every stage released and acknowledged
//             fault_o        sequencing fault latched
//             fault_stage_o  index of the stage that faulted
//  Revision : 1.0  initial release
// ============================================================================
module rst_seq #(
  parameter int IN_FREQ_KHZ      = 16000,
  parameter int NUM_STAGES       = 4,
  parameter int STAGE_DELAY_US   = 100,
  parameter int READY_TIMEOUT_US = 10000,
  localparam int STW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clkin,
  input  logic                  rst,
  input  logic                  soft_rst_i,
  input  logic [NUM_STAGES-1:0] ready_i,
  output logic [NUM_STAGES-1:0] rst_n_stage_o,
  output logic                  all_ready_o,
  output logic                  fault_o,
  output logic [STW-1:0]        fault_stage_o
);

  localparam int DLY_CYC = (IN_FREQ_KHZ / 1000) * STAGE_DELAY_US;
  localparam int TO_CYC  = (IN_FREQ_KHZ / 1000) * READY_TIMEOUT_US;
  localparam int CNT_MAX = (DLY_CYC > TO_CYC) ? DLY_CYC : TO_CYC;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0]  DLY_LAST   = CW'(DLY_CYC - 1);
  localparam logic [CW-1:0]  TO_LAST    = CW'(TO_CYC - 1);
  localparam logic [STW-1:0] LAST_STAGE = STW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    ST_DELAY    = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_DONE     = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [STW-1:0]          stage_q, stage_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]   rst_n_stage_q, rst_n_stage_d;
  logic                    all_ready_q, all_ready_d;
  logic                    fault_q, fault_d;
  logic [STW-1:0]          fault_stage_q, fault_stage_d;
  logic [NUM_STAGES-1:0]   ready_meta_q, ready_s_q;

  // Lowest-index stage whose synchronised ready is low (only meaningful in DONE).
  logic [STW-1:0] ready_low_idx;
  always_comb begin
    ready_low_idx = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!ready_s_q[i]) ready_low_idx = STW'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    stage_d       = stage_q;
    cnt_d         = cnt_q;
    rst_n_stage_d = rst_n_stage_q;
    all_ready_d   = all_ready_q;
    fault_d       = fault_q;
    fault_stage_d = fault_stage_q;

    case (state_q)
      ST_DELAY: begin
        if (cnt_q == DLY_LAST) begin
          rst_n_stage_d[stage_q] = 1'b1;
          cnt_d                  = '0;
          state_d                = ST_WAIT_RDY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_RDY: begin
        // Ready is tested before the timeout so a ready arriving on the
        // final timeout edge is still accepted.
        if (ready_s_q[stage_q]) begin
          if (stage_q == LAST_STAGE) begin
            all_ready_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            stage_d = stage_q + STW'(1);
            cnt_d   = '0;
            state_d = ST_DELAY;
          end
        end else if (cnt_q == TO_LAST) begin
          rst_n_stage_d = '0;
          all_ready_d   = 1'b0;
          fault_d       = 1'b1;
          fault_stage_d = stage_q;
          state_d       = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (!(&ready_s_q)) begin
          rst_n_stage_d = '0;
          all_ready_d   = 1'b0;
          fault_d       = 1'b1;
          fault_stage_d = ready_low_idx;
          state_d       = ST_FAULT;
        end
      end
      default: begin
        // ST_FAULT: hold everything until rst or soft_rst_i.
        state_d = ST_FAULT;
      end
    endcase
  end

  // soft_rst_i has exactly the same effect as rst, so both share one branch.
  always_ff @(posedge clkin) begin
    if (rst || soft_rst_i) begin
      state_q       <= ST_DELAY;
      stage_q       <= '0;
      cnt_q         <= '0;
      rst_n_stage_q <= '0;
      all_ready_q   <= 1'b0;
      fault_q       <= 1'b0;
      fault_stage_q <= '0;
      ready_meta_q  <= '0;
      ready_s_q     <= '0;
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      cnt_q         <= cnt_d;
      rst_n_stage_q <= rst_n_stage_d;
      all_ready_q   <= all_ready_d;
      fault_q       <= fault_d;
      fault_stage_q <= fault_stage_d;
      ready_meta_q  <= ready_i;
      ready_s_q     <= ready_meta_q;
    end
  end

  assign rst_n_stage_o = rst_n_stage_q;
  assign all_ready_o   = all_ready_q;
  assign fault_o       = fault_q;
  assign fault_stage_o = fault_stage_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rst_seq
//  Purpose  : Self-checking bench for rst_seq. A timeline model derives the
//             release, acknowledge, done and fault edges from the recorded
//             ready_i history and predicts every output after each edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rst_seq;

  localparam int IN_FREQ_KHZ      = 1000;
  localparam int NUM_STAGES       = 3;
  localparam int STAGE_DELAY_US   = 4;
  localparam int READY_TIMEOUT_US = 20;
  localparam int DLY = (IN_FREQ_KHZ / 1000) * STAGE_DELAY_US;   // 4
  localparam int TO  = (IN_FREQ_KHZ / 1000) * READY_TIMEOUT_US; // 20
  localparam int INF = 1 << 30;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic       soft_rst_i = 1'b0;
  logic [2:0] ready_i = 3'b000;
  logic [2:0] rst_n_stage_o;
  logic       all_ready_o;
  logic       fault_o;
  logic [1:0] fault_stage_o;

  always #5 clkin = ~clkin;

  rst_seq #(
    .IN_FREQ_KHZ     (IN_FREQ_KHZ),
    .NUM_STAGES      (NUM_STAGES),
    .STAGE_DELAY_US  (STAGE_DELAY_US),
    .READY_TIMEOUT_US(READY_TIMEOUT_US)
  ) dut (
    .clkin        (clkin),
    .rst          (rst),
    .soft_rst_i   (soft_rst_i),
    .ready_i      (ready_i),
    .rst_n_stage_o(rst_n_stage_o),
    .all_ready_o  (all_ready_o),
    .fault_o      (fault_o),
    .fault_stage_o(fault_stage_o)
  );

  // Packed view of all outputs: {rst_n_stage[2:0], all_ready, fault, fault_stage[1:0]}
  logic [6:0] obs;
  assign obs = {rst_n_stage_o, all_ready_o, fault_o, fault_stage_o};

  int         n_cmp = 0;
  int         n_err = 0;
  int         cur_e = 0;          // edges since the last rst/soft_rst edge
  logic [2:0] hist [0:255];       // ready_i value sampled at each edge

  // Drive inputs, take one clock edge, record it, sample at the falling edge.
  task automatic drive_edge(input logic [2:0] rdy, input logic r, input logic s);
    ready_i    = rdy;
    rst        = r;
    soft_rst_i = s;
    @(posedge clkin);
    if (r || s) begin
      cur_e = 0;
    end else if (cur_e < 255) begin
      cur_e = cur_e + 1;
      hist[cur_e] = rdy;
    end
    @(negedge clkin);
  endtask

  // Synchronised ready as seen by the sequencer at edge t: two edges of lag,
  // and zero for the first two edges since the synchroniser was cleared.
  function automatic logic rs(input int t, input int k);
    if (t >= 3) return hist[t-2][k];
    return 1'b0;
  endfunction

  // Timeline model: stage 0 releases DLY edges after reset; a stage is
  // acknowledged on the first edge within TO edges after its release where
  // its synced ready is high; the next stage releases DLY edges after that.
  // No acknowledge within TO edges faults at release+TO. After done, any low
  // ready faults with the lowest low index.
  function automatic logic [6:0] model_out(input int e);
    int rel [3];
    int fe, fst, done, t;
    logic acc, stop;
    logic [2:0] rn;
    logic ar, f;
    logic [1:0] fs;
    for (int k = 0; k < 3; k++) rel[k] = INF;
    fe = INF; fst = 0; done = INF; stop = 1'b0;
    rel[0] = DLY;
    for (int k = 0; k < 3; k++) begin
      if (!stop) begin
        acc = 1'b0;
        t = rel[k] + 1;
        while (!acc && t <= rel[k] + TO && t <= e) begin
          if (rs(t, k)) acc = 1'b1;
          else t = t + 1;
        end
        if (acc) begin
          if (k < 2) rel[k+1] = t + DLY;
          else done = t;
        end else begin
          if (rel[k] + TO <= e) begin
            fe = rel[k] + TO;
            fst = k;
          end
          stop = 1'b1;
        end
      end
    end
    if (done <= e) begin
      for (int tt = done + 1; tt <= e; tt++) begin
        if (fe == INF) begin
          for (int j = 2; j >= 0; j--) begin
            if (!rs(tt, j)) begin
              fe = tt;
              fst = j;
            end
          end
        end
      end
    end
    for (int k = 0; k < 3; k++) rn[k] = (rel[k] <= e) && (e < fe);
    ar = (done <= e) && (e < fe);
    f  = (fe <= e);
    fs = f ? 2'(fst) : 2'd0;
    return {rn, ar, f, fs};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive_edge(3'b111, 1'b1, 1'b0);
      n_cmp++;
      if (obs !== 7'b0000000) begin
        n_err++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", i, obs, 7'b0000000);
      end
    end
  endtask

  task automatic test_nominal();
    logic [6:0] exp;
    drive_edge(3'b111, 1'b1, 1'b0);
    for (int i = 0; i < 22; i++) begin
      drive_edge(3'b111, 1'b0, 1'b0);
      exp = model_out(cur_e);
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL nominal e=%0d got=%b exp=%b", cur_e, obs, exp);
      end
      // Fixed release points: stage0 @4, stage1 @9, stage2 @14, all ready @15.
      if (cur_e == 4 || cur_e == 9 || cur_e == 14 || cur_e == 15) begin
        case (cur_e)
          4:       exp = 7'b0010000;
          9:       exp = 7'b0110000;
          14:      exp = 7'b1110000;
          default: exp = 7'b1111000;
        endcase
        n_cmp++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL nominal_fixed e=%0d got=%b exp=%b", cur_e, obs, exp);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [6:0] exp;
    drive_edge(3'b101, 1'b1, 1'b0);
    for (int i = 0; i < 34; i++) begin
      drive_edge(3'b101, 1'b0, 1'b0);
      exp = model_out(cur_e);
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL timeout e=%0d got=%b exp=%b", cur_e, obs, exp);
      end
      if (cur_e == 28 || cur_e == 29) begin
        exp = (cur_e == 28) ? 7'b0110000 : 7'b0000101;
        n_cmp++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL timeout_fixed e=%0d got=%b exp=%b", cur_e, obs, exp);
        end
      end
    end
  endtask

  task automatic test_timeout_edge();
    logic [6:0] exp;
    drive_edge(3'b101, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      // ready_i[1] sampled high from edge 27 -> synced high exactly at edge 29
      drive_edge((cur_e + 1 >= 27) ? 3'b111 : 3'b101, 1'b0, 1'b0);
      exp = model_out(cur_e);
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL timeout_edge e=%0d got=%b exp=%b", cur_e, obs, exp);
      end
      if (cur_e == 29) begin
        n_cmp++;
        if (fault_o !== 1'b0) begin
          n_err++;
          $display("FAIL timeout_edge_nofault e=%0d got=%b exp=0", cur_e, fault_o);
        end
      end
    end
  endtask

  task automatic test_done_drop();
    logic [6:0] exp;
    drive_edge(3'b111, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      drive_edge((cur_e + 1 >= 20 && cur_e + 1 < 23) ? 3'b011 : 3'b111, 1'b0, 1'b0);
      exp = model_out(cur_e);
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL done_drop e=%0d got=%b exp=%b", cur_e, obs, exp);
      end
      if (cur_e == 22 || cur_e == 40) begin
        n_cmp++;
        if (obs !== 7'b0000110) begin
          n_err++;
          $display("FAIL done_drop_fixed e=%0d got=%b exp=%b", cur_e, obs, 7'b0000110);
        end
      end
    end
  endtask

  // Entered with the DUT latched in FAULT by the previous scenario.
  task automatic test_soft_reset();
    logic [6:0] exp;
    n_cmp++;
    if (fault_o !== 1'b1) begin
      n_err++;
      $display("FAIL soft_pre_fault got=%b exp=1", fault_o);
    end
    drive_edge(3'b111, 1'b0, 1'b1);
    n_cmp++;
    if (obs !== 7'b0000000) begin
      n_err++;
      $display("FAIL soft_clear got=%b exp=%b", obs, 7'b0000000);
    end
    for (int i = 0; i < 20; i++) begin
      drive_edge(3'b111, 1'b0, 1'b0);
      exp = model_out(cur_e);
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL soft_seq e=%0d got=%b exp=%b", cur_e, obs, exp);
      end
      if (cur_e == 15) begin
        n_cmp++;
        if (obs !== 7'b1111000) begin
          n_err++;
          $display("FAIL soft_seq_done got=%b exp=%b", obs, 7'b1111000);
        end
      end
    end
  endtask

  task automatic test_mid_rst();
    logic [6:0] exp;
    drive_edge(3'b111, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) drive_edge(3'b111, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== 7'b0010000) begin
      n_err++;
      $display("FAIL mid_rst_pre got=%b exp=%b", obs, 7'b0010000);
    end
    drive_edge(3'b111, 1'b1, 1'b0);
    n_cmp++;
    if (obs !== 7'b0000000) begin
      n_err++;
      $display("FAIL mid_rst_clear got=%b exp=%b", obs, 7'b0000000);
    end
    for (int i = 0; i < 18; i++) begin
      drive_edge(3'b111, 1'b0, 1'b0);
      exp = model_out(cur_e);
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL mid_rst_seq e=%0d got=%b exp=%b", cur_e, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] exp;
    logic [2:0] rdy;
    int rise [3];
    int dk, d0, dl, nx;
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < 3; k++) rise[k] = $urandom_range(1, 32);
      dk = $urandom_range(0, 2);
      d0 = $urandom_range(1, 60);
      dl = $urandom_range(1, 3);
      drive_edge(3'b000, 1'b1, 1'b0);
      for (int i = 0; i < 60; i++) begin
        nx = cur_e + 1;
        for (int k = 0; k < 3; k++)
          rdy[k] = (nx >= rise[k]) && !(k == dk && nx >= d0 && nx < d0 + dl);
        drive_edge(rdy, 1'b0, 1'b0);
        exp = model_out(cur_e);
        n_cmp++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL random it=%0d e=%0d got=%b exp=%b", it, cur_e, obs, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_timeout_edge();
    test_done_drop();
    test_soft_reset();
    test_mid_rst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
